// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default widths and loader states.
package imem_pkg;

  localparam int IW_DEFAULT = 9;
  localparam int AW_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } ld_state_t;

endpackage

// File: rtl/imem_array.sv
// Program store: 2^AW x IW words, one synchronous write port and one asynchronous read port.
module imem_array #(
  parameter int IW = 9,
  parameter int AW = 10
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  // No reset here: the program image survives a processor reset.
  logic [IW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory owner: streams a program image into the store while the fetch unit is held
// via Busy, and serves combinational reads at the program counter.
module imem_loader
  import imem_pkg::*;
#(
  parameter int IW = IW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          LoadReq,
  input  logic [AW-1:0] BaseAddr,
  input  logic [AW:0]   Count,
  input  logic          InValid,
  input  logic [IW-1:0] InData,
  output logic          InReady,
  input  logic [AW-1:0] ProgCtr,
  output logic [IW-1:0] InstOut,
  output logic          Busy,
  output logic          Done,
  output logic          Overflow,
  output logic [IW-1:0] Checksum
);

  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW-1:0] PTR_LAST = '1;
  localparam logic [AW:0]   CNT_ZERO = '0;
  localparam logic [AW:0]   CNT_ONE  = 1;

  ld_state_t     state;
  ld_state_t     nextState;
  logic [AW-1:0] wrPtr;
  logic [AW:0]   remaining;
  logic [IW-1:0] checksum;
  logic          overflow;
  logic          accept;

  assign accept = InReady && InValid;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // The final accept goes straight to DONE, so Remaining never reaches zero inside LOAD.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (LoadReq) begin
          nextState = (Count == CNT_ZERO) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && (remaining == CNT_ONE)) begin
          nextState = DONE;
        end
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    InReady = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state)
      LOAD: begin
        InReady = 1'b1;
        Busy    = 1'b1;
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // Checksum and Overflow describe the current or last load, so only a new request clears them.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr     <= '0;
      remaining <= '0;
      checksum  <= '0;
      overflow  <= 1'b0;
    end else if ((state == IDLE) && LoadReq) begin
      wrPtr     <= BaseAddr;
      remaining <= Count;
      checksum  <= '0;
      overflow  <= 1'b0;
    end else if (accept) begin
      wrPtr     <= wrPtr + PTR_ONE;
      remaining <= remaining - CNT_ONE;
      checksum  <= checksum ^ InData;
      if (wrPtr == PTR_LAST) begin
        overflow <= 1'b1;
      end
    end
  end

  assign Checksum = checksum;
  assign Overflow = overflow;

  imem_array #(
    .IW(IW),
    .AW(AW)
  ) u_array (
    .Clk  (Clk),
    .we   (accept),
    .waddr(wrPtr),
    .wdata(InData),
    .raddr(ProgCtr),
    .rdata(InstOut)
  );

endmodule
